mem_arbiter: RTL and testbench

- Shares the single-port system memory between the CPU core and the PPU.
- Contains the OAM DMA sequencer: a CPU write to 0x4014 stalls the CPU and copies 256 bytes from page XX00 to the OAM data port.
- Sits between the requesters and the memory model. The memory sees one request per cycle and returns read data one cycle later.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 35 +++
 rtl/mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory arbiter and OAM DMA sequencer.
package mem_arb_pkg;

  // Arbiter / DMA sequencer state.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DMA_ALIGN = 2'd1,
    DMA_RD    = 2'd2,
    DMA_WR    = 2'd3
  } arb_state_t;

  // Who issued the read whose data returns on mem_rdata this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_PPU  = 2'd2,
    OWN_DMA  = 2'd3
  } rd_owner_t;

  localparam logic [15:0] DMA_TRIG_ADDR_DEF = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR_DEF  = 16'h2004;
  localparam int          DMA_LEN_DEF       = 256;

  // The DMA byte index is a single byte; it never carries into the page.
  localparam int DMA_IDX_W = 8;

  // True when idx addresses the final byte of a transfer of len bytes.
  function automatic logic is_last_idx(input logic [DMA_IDX_W-1:0] idx, input int len);
    return idx == DMA_IDX_W'(len - 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 = CPU, bit 1 = PPU.
// The last-grant pointer resets to "PPU last" so the CPU wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last_ppu;

  // Grant selection: a lone requester wins, a tie goes to whoever was not last.
  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_last_ppu ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  // Remember the most recent winner while the arbiter is in use.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_ppu <= 1'b1;
    end else if (i_en && (|o_gnt)) begin
      r_last_ppu <= o_gnt[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between CPU and PPU, with the OAM DMA sequencer.
// A CPU write to the trigger address stalls the CPU and streams DMA_LEN bytes
// from page {page, 00} to the OAM data port, one read + one write per byte.
// The PPU keeps priority over DMA reads so rendering is never starved.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [ADDR_WIDTH-1:0] DMA_TRIG_ADDR = ADDR_WIDTH'(DMA_TRIG_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] OAMDATA_ADDR  = ADDR_WIDTH'(OAMDATA_ADDR_DEF),
  parameter int                    DMA_LEN       = DMA_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  // CPU port
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  // PPU port
  input  logic                  ppu_req,
  input  logic                  ppu_we,
  input  logic [ADDR_WIDTH-1:0] ppu_addr,
  input  logic [DATA_WIDTH-1:0] ppu_wdata,
  output logic                  ppu_gnt,
  output logic                  ppu_rvalid,
  output logic [DATA_WIDTH-1:0] ppu_rdata,
  // Memory port
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  // Status
  output logic                  dma_busy
);

  arb_state_t             r_state;
  rd_owner_t              r_owner;
  logic [DATA_WIDTH-1:0]  r_page;
  logic [DMA_IDX_W-1:0]   r_idx;
  logic [DATA_WIDTH-1:0]  r_cpu_rdata;
  logic [DATA_WIDTH-1:0]  r_ppu_rdata;

  logic                   w_arb_en;
  logic [1:0]             w_arb_gnt;
  logic                   w_cpu_gnt;
  logic                   w_ppu_gnt;
  logic                   w_dma_rd;
  logic                   w_dma_wr;
  logic                   w_dma_trig;
  logic                   w_busy;
  logic [ADDR_WIDTH-1:0]  w_dma_addr;

  // Round-robin only matters in IDLE; elsewhere the DMA sequencer decides.
  assign w_arb_en = (r_state == IDLE) && !reset;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_arb_en),
    .i_req ({ppu_req, cpu_req}),
    .o_gnt (w_arb_gnt)
  );

  // Source byte address: page in the high byte, index in the low byte, no carry.
  assign w_dma_addr = ADDR_WIDTH'({r_page, r_idx});

  // A DMA only starts from a CPU write; a PPU write to the same address is plain.
  assign w_dma_trig = w_cpu_gnt && cpu_we && (cpu_addr == DMA_TRIG_ADDR);

  assign w_busy    = (r_state != IDLE) && !reset;
  assign cpu_stall = w_busy;
  assign dma_busy  = w_busy;
  assign cpu_gnt   = w_cpu_gnt;
  assign ppu_gnt   = w_ppu_gnt;

  // Per-state grant decision and memory bus steering toward the winner.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_ppu_gnt = 1'b0;
    w_dma_rd  = 1'b0;
    w_dma_wr  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (!reset) begin
      case (r_state)
        IDLE: begin
          w_cpu_gnt = w_arb_gnt[0];
          w_ppu_gnt = w_arb_gnt[1];
        end
        DMA_ALIGN: begin
          w_ppu_gnt = ppu_req;
        end
        DMA_RD: begin
          if (ppu_req) begin
            w_ppu_gnt = 1'b1;
          end else begin
            w_dma_rd = 1'b1;
          end
        end
        DMA_WR: begin
          w_dma_wr = 1'b1;
        end
      endcase
    end

    if (w_cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_ppu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ppu_we;
      mem_addr  = ppu_addr;
      mem_wdata = ppu_wdata;
    end else if (w_dma_rd) begin
      mem_en    = 1'b1;
      mem_addr  = w_dma_addr;
    end else if (w_dma_wr) begin
      // The byte read in the previous cycle is forwarded straight to OAM.
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = OAMDATA_ADDR;
      mem_wdata = mem_rdata;
    end
  end

  // DMA sequencer: trigger, one alignment cycle, then read/write pairs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_page  <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dma_trig) begin
            r_page  <= cpu_wdata;
            r_idx   <= '0;
            r_state <= DMA_ALIGN;
          end
        end
        DMA_ALIGN: begin
          r_state <= DMA_RD;
        end
        DMA_RD: begin
          // A PPU access in this slot pushes the DMA read back by one cycle.
          if (w_dma_rd) begin
            r_state <= DMA_WR;
          end
        end
        DMA_WR: begin
          if (is_last_idx(r_idx, DMA_LEN)) begin
            r_idx   <= '0;
            r_state <= IDLE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= DMA_RD;
          end
        end
      endcase
    end
  end

  // Track which requester owns the read data returning next cycle, and keep
  // each requester's last returned byte so its rdata holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= OWN_NONE;
      r_cpu_rdata <= '0;
      r_ppu_rdata <= '0;
    end else begin
      if (w_cpu_gnt && !cpu_we) begin
        r_owner <= OWN_CPU;
      end else if (w_ppu_gnt && !ppu_we) begin
        r_owner <= OWN_PPU;
      end else if (w_dma_rd) begin
        r_owner <= OWN_DMA;
      end else begin
        r_owner <= OWN_NONE;
      end

      if (r_owner == OWN_CPU) begin
        r_cpu_rdata <= mem_rdata;
      end
      if (r_owner == OWN_PPU) begin
        r_ppu_rdata <= mem_rdata;
      end
    end
  end

  // DMA-owned returns are consumed by the write path and never flagged valid.
  assign cpu_rvalid = (r_owner == OWN_CPU);
  assign ppu_rvalid = (r_owner == OWN_PPU);
  assign cpu_rdata  = (r_owner == OWN_CPU) ? mem_rdata : r_cpu_rdata;
  assign ppu_rdata  = (r_owner == OWN_PPU) ? mem_rdata : r_ppu_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        ppu_req, ppu_we, ppu_gnt, ppu_rvalid;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_wdata, ppu_rdata;
  logic        mem_en, mem_we, dma_busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:65535];
  logic        init_done = 1'b0;
  logic [7:0]  wq[$];
  logic [15:0] rq[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .ppu_req    (ppu_req),
    .ppu_we     (ppu_we),
    .ppu_addr   (ppu_addr),
    .ppu_wdata  (ppu_wdata),
    .ppu_gnt    (ppu_gnt),
    .ppu_rvalid (ppu_rvalid),
    .ppu_rdata  (ppu_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dma_busy   (dma_busy)
  );

  // Memory model: preload on the first edge, then one access per cycle.
  // Also logs OAM writes and DMA source reads in order.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] <= 8'(i) ^ 8'h5A;
      mem[16'h0010] <= 8'hA5;
      mem[16'h0011] <= 8'h3C;
      init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
      if (mem_we && mem_addr == 16'h2004) wq.push_back(mem_wdata);
      if (!mem_we && dma_busy && !ppu_gnt) rq.push_back(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present the DMA trigger write from the CPU; it commits on the next edge.
  task automatic trigger(input logic [7:0] page);
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = page;
    #1;
    chk("trig_cpu_gnt", 32'(cpu_gnt), 32'd1);
  endtask

  // Step through a DMA until cpu_stall falls or max_n cycles elapse. The CPU
  // keeps requesting a read throughout; the PPU reads in cycles ppu_from..ppu_to.
  task automatic run_dma(input int max_n, input int ppu_from, input int ppu_to,
                         output int stalls, output int ppu_gnts, output int cpu_gnts,
                         output int rvalids, output logic en_align,
                         output logic [15:0] rd0, output logic [15:0] wr0);
    stalls = 0; ppu_gnts = 0; cpu_gnts = 0; rvalids = 0;
    en_align = 1'b1; rd0 = '0; wr0 = '0;
    for (int n = 1; n <= max_n; n++) begin
      cyc();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      ppu_req = (n >= ppu_from && n <= ppu_to); ppu_we = 1'b0; ppu_addr = 16'h0011;
      #1;
      if (!cpu_stall) break;
      stalls++;
      if (ppu_gnt) ppu_gnts++;
      if (cpu_gnt) cpu_gnts++;
      if (cpu_rvalid || ppu_rvalid) rvalids++;
      if (n == 1) en_align = mem_en;
      if (n == 2) rd0 = mem_addr;
      if (n == 3) wr0 = mem_addr;
    end
    ppu_req = 1'b0;
  endtask

  // Check a full DMA's OAM data and source addresses against i ^ 0x5A / 0x0200+i.
  task automatic check_log(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_wcount"}, 32'(wq.size()), 32'd256);
    chk({tag, "_rcount"}, 32'(rq.size()), 32'd256);
    for (int i = 0; i < wq.size() && i < 256; i++)
      if (wq[i] !== (8'(i) ^ 8'h5A)) bad++;
    for (int i = 0; i < rq.size() && i < 256; i++)
      if (rq[i] !== (16'h0200 + 16'(i))) bad++;
    chk({tag, "_order"}, 32'(bad), 32'd0);
  endtask

  int          st, pg, cg, rv;
  logic        ea;
  logic [15:0] a_rd, a_wr;

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ppu_req = 0; ppu_we = 0; ppu_addr = '0; ppu_wdata = '0;

    // Reset values
    cyc(); cyc(); #1;
    chk("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
    chk("rst_ppu_gnt",    32'(ppu_gnt),    32'd0);
    chk("rst_mem_en",     32'(mem_en),     32'd0);
    chk("rst_mem_we",     32'(mem_we),     32'd0);
    chk("rst_mem_addr",   32'(mem_addr),   32'd0);
    chk("rst_cpu_stall",  32'(cpu_stall),  32'd0);
    chk("rst_dma_busy",   32'(dma_busy),   32'd0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_ppu_rvalid", 32'(ppu_rvalid), 32'd0);
    chk("rst_cpu_rdata",  32'(cpu_rdata),  32'd0);
    chk("rst_ppu_rdata",  32'(ppu_rdata),  32'd0);

    // CPU read of 0x0010 with the PPU idle
    cyc();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    #1;
    chk("rd_cpu_gnt",  32'(cpu_gnt),  32'd1);
    chk("rd_ppu_gnt",  32'(ppu_gnt),  32'd0);
    chk("rd_mem_addr", 32'(mem_addr), 32'h0010);
    chk("rd_mem_we",   32'(mem_we),   32'd0);
    cyc();
    cpu_req = 1'b0;
    #1;
    chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd_cpu_rdata",  32'(cpu_rdata),  32'hA5);
    chk("rd_ppu_rvalid", 32'(ppu_rvalid), 32'd0);
    cyc(); #1;
    chk("rd_cpu_rvalid_drop", 32'(cpu_rvalid), 32'd0);
    chk("rd_cpu_rdata_hold",  32'(cpu_rdata),  32'hA5);

    // Round-robin tie right after reset: CPU, PPU, CPU, PPU
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 16'h0011;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      #1;
      chk("rr_cpu_gnt", 32'(cpu_gnt), 32'(k % 2 == 0));
      chk("rr_ppu_gnt", 32'(ppu_gnt), 32'(k % 2 == 1));
      if (k == 1) chk("rr_cpu_rdata", 32'(cpu_rdata), 32'hA5);
      if (k == 2) chk("rr_ppu_rdata", 32'(ppu_rdata), 32'h3C);
    end
    cyc();
    cpu_req = 1'b0; ppu_req = 1'b0;

    // Uncontended DMA from page 0x02
    wq.delete(); rq.delete();
    trigger(8'h02);
    chk("trig_no_stall_yet", 32'(cpu_stall), 32'd0);
    run_dma(600, 0, -1, st, pg, cg, rv, ea, a_rd, a_wr);
    chk("dma_stall_cycles", 32'(st),   32'd513);
    chk("dma_cpu_ignored",  32'(cg),   32'd0);
    chk("dma_no_rvalid",    32'(rv),   32'd0);
    chk("dma_align_idle",   32'(ea),   32'd0);
    chk("dma_first_rd",     32'(a_rd), 32'h0200);
    chk("dma_first_wr",     32'(a_wr), 32'h2004);
    chk("dma_busy_after",   32'(dma_busy), 32'd0);
    check_log("dma");
    cpu_req = 1'b0;

    // PPU takes 10 consecutive DMA_RD slots mid-transfer
    wq.delete(); rq.delete();
    trigger(8'h02);
    run_dma(700, 20, 29, st, pg, cg, rv, ea, a_rd, a_wr);
    chk("ppu_dma_stall_cycles", 32'(st), 32'd523);
    chk("ppu_dma_ppu_gnts",     32'(pg), 32'd10);
    chk("ppu_dma_rvalids",      32'(rv), 32'd10);
    check_log("ppu_dma");
    cpu_req = 1'b0;

    // Reset while DMA is reading byte 100
    wq.delete(); rq.delete();
    trigger(8'h02);
    run_dma(202, 0, -1, st, pg, cg, rv, ea, a_rd, a_wr);
    chk("abort_rd_addr", 32'(mem_addr), 32'h0264);
    reset = 1'b1;
    cpu_req = 1'b0;
    cyc(); #1;
    chk("abort_stall",  32'(cpu_stall), 32'd0);
    chk("abort_busy",   32'(dma_busy),  32'd0);
    chk("abort_mem_en", 32'(mem_en),    32'd0);
    reset = 1'b0;
    wq.delete(); rq.delete();
    trigger(8'h02);
    run_dma(600, 0, -1, st, pg, cg, rv, ea, a_rd, a_wr);
    chk("restart_stall_cycles", 32'(st),   32'd513);
    chk("restart_first_rd",     32'(a_rd), 32'h0200);
    check_log("restart");
    cpu_req = 1'b0;

    // PPU write to the trigger address is an ordinary write
    cyc();
    ppu_req = 1'b1; ppu_we = 1'b1; ppu_addr = 16'h4014; ppu_wdata = 8'h03;
    #1;
    chk("ppuw_gnt",   32'(ppu_gnt),   32'd1);
    chk("ppuw_we",    32'(mem_we),    32'd1);
    chk("ppuw_addr",  32'(mem_addr),  32'h4014);
    chk("ppuw_wdata", 32'(mem_wdata), 32'h03);
    cyc();
    ppu_req = 1'b0;
    #1;
    chk("ppuw_busy",  32'(dma_busy),  32'd0);
    chk("ppuw_stall", 32'(cpu_stall), 32'd0);
    chk("ppuw_mem",   32'(mem[16'h4014]), 32'h03);
    cyc(); #1;
    chk("ppuw_busy_later", 32'(dma_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
